// File: rtl/cp0_pkg.sv
// cp0_pkg: CP0 register addresses, exception codes and write masks
package cp0_pkg;
  localparam logic [6:0] CP0_BADVADDR = {5'd8, 2'd0};
  localparam logic [6:0] CP0_COUNT = {5'd9, 2'd0};
  localparam logic [6:0] CP0_COMPARE = {5'd11, 2'd0};
  localparam logic [6:0] CP0_STATUS = {5'd12, 2'd0};
  localparam logic [6:0] CP0_CAUSE = {5'd13, 2'd0};
  localparam logic [6:0] CP0_EPC = {5'd14, 2'd0};
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] STATUS_EXL = 32'h0000_0002;
  localparam logic [31:0] CAUSE_WMASK = 32'h0000_0300;
  typedef enum logic [4:0] {
    EXC_INT = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS = 5'd8,
    EXC_BP = 5'd9,
    EXC_RI = 5'd10,
    EXC_OV = 5'd12
  } exc_code_t;
endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare timer (clk, rst, count_we/compare_we + wdata in; count, compare, timer_int out)
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_int
);
  logic tick;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tick <= 1'b0;
      count <= 32'd0;
      compare <= 32'd0;
      timer_int <= 1'b0;
    end else begin
      tick <= count_we ? 1'b0 : (COUNT_DIV == 2) ? ~tick : 1'b0;
      count <= count_we ? wdata : (COUNT_DIV == 1 || tick) ? count + 32'd1 : count;
      compare <= compare_we ? wdata : compare;
      // a Compare write acknowledges the interrupt and beats a same-cycle match
      timer_int <= compare_we ? 1'b0 : timer_int | (count == compare);
    end
endmodule

// File: rtl/cp0_regfile.sv
// cp0_regfile: MIPS32 CP0 (BadVAddr/Count/Compare/Status/Cause/EPC) with MTC0/MFC0, exception commit, ERET and int_req
module cp0_regfile
  import cp0_pkg::*;
#(
  parameter logic [31:0] STATUS_RST = 32'h0040_0000,
  parameter int          COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mtc0_we,
  input  logic [6:0]  mtc0_addr,
  input  logic [31:0] mtc0_wdata,
  input  logic [6:0]  mfc0_addr,
  output logic [31:0] mfc0_rdata,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic [31:0] exc_badvaddr,
  input  logic        eret,
  input  logic [5:0]  hw_int,
  output logic        int_req,
  output logic [31:0] epc_out,
  output logic [31:0] status_out,
  output logic [31:0] cause_out
);
  logic [31:0] status, epc, badvaddr, count, compare, cause_sw, status_wr;
  logic [4:0] code_q;
  logic [5:0] ip_hw;
  logic bd, timer_int, wr;
  // a committing exception flushes the MTC0 in the same cycle
  assign wr = mtc0_we & ~exc_valid;
  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk(clk),
    .rst(rst),
    .count_we(wr && mtc0_addr == CP0_COUNT),
    .compare_we(wr && mtc0_addr == CP0_COMPARE),
    .wdata(mtc0_wdata),
    .count(count),
    .compare(compare),
    .timer_int(timer_int)
  );
  always_comb begin
    status_wr = (wr && mtc0_addr == CP0_STATUS) ? (status & ~STATUS_WMASK) | (mtc0_wdata & STATUS_WMASK) : status;
    status_wr = exc_valid ? status | STATUS_EXL : eret ? status_wr & ~STATUS_EXL : status_wr;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      status <= STATUS_RST;
      epc <= 32'd0;
      badvaddr <= 32'd0;
      cause_sw <= 32'd0;
      code_q <= 5'd0;
      ip_hw <= 6'd0;
      bd <= 1'b0;
    end else begin
      status <= status_wr;
      ip_hw <= {hw_int[5] | timer_int, hw_int[4:0]};
      code_q <= exc_valid ? exc_code : code_q;
      // nested exceptions (EXL already set) keep the original return point
      epc <= (exc_valid && !status[1]) ? (exc_bd ? exc_pc - 32'd4 : exc_pc) :
             (wr && mtc0_addr == CP0_EPC) ? mtc0_wdata : epc;
      bd <= (exc_valid && !status[1]) ? exc_bd : bd;
      badvaddr <= (exc_valid && (exc_code == EXC_ADEL || exc_code == EXC_ADES)) ? exc_badvaddr : badvaddr;
      cause_sw <= (wr && mtc0_addr == CP0_CAUSE) ? mtc0_wdata & CAUSE_WMASK : cause_sw;
    end
  assign cause_out = {bd, timer_int, 14'd0, ip_hw, 3'd0, code_q, 2'd0} | cause_sw;
  assign status_out = status;
  assign epc_out = epc;
  assign int_req = ~rst & status[0] & ~status[1] & |(cause_out[15:8] & status[15:8]);
  assign mfc0_rdata = mfc0_addr == CP0_BADVADDR ? badvaddr :
                      mfc0_addr == CP0_COUNT ? count :
                      mfc0_addr == CP0_COMPARE ? compare :
                      mfc0_addr == CP0_STATUS ? status :
                      mfc0_addr == CP0_CAUSE ? cause_out :
                      mfc0_addr == CP0_EPC ? epc : 32'd0;
endmodule
